// File: rtl/spi_mult_store_seq.sv
// Purpose: SPI master that multiplies a*b on an external multiplier, stores the product to an external memory and reads it back.
// Latency: 59 SCLK periods (default parameters) from start to the one-CLK done pulse, plus one FINISH cycle.
// Backpressure: none; start is only accepted in IDLE, starts while busy or in FINISH are dropped.
//
// Ports:
//   CLK, RST            system clock, asynchronous active-high reset
//   start, a, b, addr   request pulse and operands/address (latched on accept)
//   busy, done          sequence in progress, one-CLK completion pulse
//   product, readback   multiplier result and memory readback (updated in FINISH)
//   match               readback == product (updated in FINISH)
//   SCLK, MOSI          shared SPI clock (idle low) and data out
//   MultCS, MultMISO    multiplier select (active high) and its data in
//   MemCS, MemMISO      memory select (active low) and its data in
module spi_mult_store_seq #(
  parameter int SCLK_HALF = 5,
  parameter int MULT_WAIT = 5,
  parameter int READ_WAIT = 3
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       start,
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic [6:0] addr,
  output logic       busy,
  output logic       done,
  output logic [7:0] product,
  output logic [7:0] readback,
  output logic       match,
  output logic       SCLK,
  output logic       MOSI,
  output logic       MultCS,
  output logic       MemCS,
  input  logic       MultMISO,
  input  logic       MemMISO
);

  typedef enum logic [3:0] {
    IDLE, M_SEL, M_SHIFT, M_WAIT, M_READ, W_ADDR, W_GAP,
    W_DATA, W_GAP2, R_ADDR, R_WAIT, R_READ, FINISH
  } state_t;

  localparam int HW = (SCLK_HALF > 1) ? $clog2(SCLK_HALF) : 1;
  localparam logic [HW-1:0] HALF_LAST = HW'(SCLK_HALF - 1);

  state_t        state;
  logic [HW-1:0] hcnt;     // CLK cycles within the current SCLK half
  logic [7:0]    pcnt;     // SCLK periods within the current state
  logic [3:0]    a_l, b_l;
  logic [6:0]    addr_l;
  logic [7:0]    prod_sr, rb_sr;

  // Values that take effect at the next SCLK falling edge.
  logic [7:0] term, nxt_pcnt, ab, wa, ra;
  logic       per_end, nxt_mosi;
  logic [2:0] bi;
  state_t     succ, nxt_state;

  always_comb begin
    term = 8'd7;
    case (state)
      M_SEL, W_GAP, W_GAP2: term = 8'd0;
      M_WAIT:               term = 8'(MULT_WAIT - 1);
      R_WAIT:               term = 8'(READ_WAIT - 1);
      default:              term = 8'd7;
    endcase
    per_end = (pcnt == term);

    succ = IDLE;
    case (state)
      M_SEL:   succ = M_SHIFT;
      M_SHIFT: succ = M_WAIT;
      M_WAIT:  succ = M_READ;
      M_READ:  succ = W_ADDR;
      W_ADDR:  succ = W_GAP;
      W_GAP:   succ = W_DATA;
      W_DATA:  succ = W_GAP2;
      W_GAP2:  succ = R_ADDR;
      R_ADDR:  succ = R_WAIT;
      R_WAIT:  succ = R_READ;
      R_READ:  succ = FINISH;
      default: succ = IDLE;
    endcase

    // Period counter stops at its terminal count and restarts with the next field.
    nxt_state = per_end ? succ : state;
    nxt_pcnt  = per_end ? 8'd0 : pcnt + 8'd1;
    bi        = 3'd7 - nxt_pcnt[2:0];   // MSB first
    ab        = {a_l, b_l};
    wa        = {1'b0, addr_l};
    ra        = {1'b1, addr_l};
    nxt_mosi  = 1'b0;
    case (nxt_state)
      M_SHIFT: nxt_mosi = ab[bi];
      W_ADDR:  nxt_mosi = wa[bi];
      W_DATA:  nxt_mosi = prod_sr[bi];
      R_ADDR:  nxt_mosi = ra[bi];
      default: nxt_mosi = 1'b0;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= IDLE;
      hcnt     <= '0;
      pcnt     <= '0;
      a_l      <= '0;
      b_l      <= '0;
      addr_l   <= '0;
      prod_sr  <= '0;
      rb_sr    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      product  <= '0;
      readback <= '0;
      match    <= 1'b0;
      SCLK     <= 1'b0;
      MOSI     <= 1'b0;
      MultCS   <= 1'b0;
      MemCS    <= 1'b1;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_l    <= a;
            b_l    <= b;
            addr_l <= addr;
            busy   <= 1'b1;
            MultCS <= 1'b1;
            MOSI   <= 1'b0;
            SCLK   <= 1'b0;
            hcnt   <= '0;
            pcnt   <= '0;
            state  <= M_SEL;
          end
        end
        FINISH: state <= IDLE;
        default: begin
          if (hcnt == HALF_LAST) begin
            hcnt <= '0;
            if (!SCLK) begin
              // Rising edge: sample the selected slave.
              SCLK <= 1'b1;
              if (state == M_READ) prod_sr <= {prod_sr[6:0], MultMISO};
              if (state == R_READ) rb_sr   <= {rb_sr[6:0], MemMISO};
            end else begin
              // Falling edge: period boundary, MOSI and state advance here.
              SCLK  <= 1'b0;
              state <= nxt_state;
              pcnt  <= nxt_pcnt;
              MOSI  <= nxt_mosi;
              if (per_end) begin
                case (state)
                  M_READ: begin
                    // Hand-over in one edge: MultCS drops as MemCS asserts.
                    MultCS <= 1'b0;
                    MemCS  <= 1'b0;
                  end
                  R_READ: begin
                    MemCS    <= 1'b1;
                    busy     <= 1'b0;
                    done     <= 1'b1;
                    product  <= prod_sr;
                    readback <= rb_sr;
                    match    <= (rb_sr == prod_sr);
                  end
                  default: ;
                endcase
              end
            end
          end else begin
            hcnt <= hcnt + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_mult_store_seq.sv
module tb_spi_mult_store_seq;

  localparam int SCLK_HALF = 5;
  localparam int MULT_WAIT = 5;
  localparam int READ_WAIT = 3;
  localparam int RISES     = 1 + 8 + MULT_WAIT + 8 + 8 + 1 + 8 + 1 + 8 + READ_WAIT + 8;
  localparam int MULT_RD0  = 1 + 8 + MULT_WAIT + 1;   // first multiplier read edge
  localparam int MEM_RD0   = 26 + READ_WAIT + 1;      // first memory read edge
  localparam int BUDGET    = 4 * RISES * 2 * SCLK_HALF;

  logic       CLK, RST, start;
  logic [3:0] a, b;
  logic [6:0] addr;
  logic       busy, done, match, SCLK, MOSI, MultCS, MemCS, MultMISO, MemMISO;
  logic [7:0] product, readback;

  spi_mult_store_seq #(.SCLK_HALF(SCLK_HALF), .MULT_WAIT(MULT_WAIT), .READ_WAIT(READ_WAIT)) dut (
    .CLK(CLK), .RST(RST), .start(start), .a(a), .b(b), .addr(addr),
    .busy(busy), .done(done), .product(product), .readback(readback), .match(match),
    .SCLK(SCLK), .MOSI(MOSI), .MultCS(MultCS), .MemCS(MemCS),
    .MultMISO(MultMISO), .MemMISO(MemMISO)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // ---------------- multiplier slave model ----------------
  int         m_edge = 0;
  logic [7:0] m_ops, m_prod;
  always @(posedge SCLK or negedge SCLK or negedge MultCS) begin
    if (!MultCS) begin
      m_edge   = 0;
      MultMISO = 1'b0;
    end else if (SCLK) begin
      m_edge++;
      if (m_edge >= 2 && m_edge <= 9) m_ops = {m_ops[6:0], MOSI};
      if (m_edge == 9) m_prod = 8'(m_ops[7:4]) * 8'(m_ops[3:0]);
    end else begin
      int nx;
      nx = m_edge + 1;
      MultMISO = (nx >= MULT_RD0 && nx < MULT_RD0 + 8) ? m_prod[7 - (nx - MULT_RD0)] : 1'b0;
    end
  end

  // ---------------- memory slave model ----------------
  logic [7:0] mem [128];
  bit         mem_init = 0;
  bit         mem_tie0 = 0;
  int         r_edge = 0;
  logic [7:0] r_sh, r_byte;
  logic [6:0] mem_waddr, mem_raddr;
  bit         r_wcmd, r_rcmd;
  always @(posedge SCLK or negedge SCLK or posedge MemCS) begin
    if (MemCS) begin
      if (!mem_init) begin
        for (int i = 0; i < 128; i++) mem[i] = 8'(i) ^ 8'hA5;
        mem_init = 1;
      end
      r_edge  = 0;
      MemMISO = 1'b0;
    end else if (SCLK) begin
      r_edge++;
      if ((r_edge >= 1 && r_edge <= 8) || (r_edge >= 10 && r_edge <= 17) || (r_edge >= 19 && r_edge <= 26))
        r_sh = {r_sh[6:0], MOSI};
      if (r_edge == 8)  begin mem_waddr = r_sh[6:0]; r_wcmd = !r_sh[7]; end
      if (r_edge == 17 && r_wcmd) mem[mem_waddr] = r_sh;
      if (r_edge == 26) begin mem_raddr = r_sh[6:0]; r_rcmd = r_sh[7]; end
    end else begin
      int nx;
      nx = r_edge + 1;
      r_byte = mem[mem_raddr];
      MemMISO = (!mem_tie0 && r_rcmd && nx >= MEM_RD0 && nx < MEM_RD0 + 8) ? r_byte[7 - (nx - MEM_RD0)] : 1'b0;
    end
  end

  // ---------------- side observers ----------------
  int total_rises = 0;
  always @(posedge SCLK) total_rises++;
  int cs_overlap = 0;
  always @(negedge CLK) if (MultCS && !MemCS) cs_overlap++;

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [7:0] prod;
    logic [7:0] rb;
    logic       match;
    logic [6:0] addr;
  } exp_t;
  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;
  bit stim_done = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic issue(input logic [3:0] ia, input logic [3:0] ib, input logic [6:0] iaddr,
                       input bit tie0, input bit push);
    exp_t e;
    @(negedge CLK);
    mem_tie0 = tie0;
    a = ia; b = ib; addr = iaddr; start = 1'b1;
    if (push) begin
      e.prod  = 8'(ia) * 8'(ib);
      e.rb    = tie0 ? 8'h00 : e.prod;
      e.match = (e.rb == e.prod);
      e.addr  = iaddr;
      exp_q.push_back(e);
    end
    @(negedge CLK);
    start = 1'b0;
    a = 4'($urandom); b = 4'($urandom); addr = 7'($urandom);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!done && n < BUDGET) begin
      @(negedge CLK);
      n++;
    end
    if (!done) chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_rises(input int cnt);
    int n, seen;
    logic prev;
    n = 0; seen = 0; prev = SCLK;
    while (seen < cnt && n < BUDGET) begin
      @(negedge CLK);
      if (SCLK && !prev) seen++;
      prev = SCLK;
      n++;
    end
    if (seen < cnt) chk("sclk_rise_timeout", 32'(seen), 32'(cnt));
  endtask

  initial begin
    RST = 1'b1; start = 1'b0; a = '0; b = '0; addr = '0;
    fork
      // ---- stimulus ----
      begin
        repeat (3) @(negedge CLK);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_sclk", 32'(SCLK), 0);
        chk("rst_mosi", 32'(MOSI), 0);
        chk("rst_multcs", 32'(MultCS), 0);
        chk("rst_memcs", 32'(MemCS), 1);
        chk("rst_outputs", {7'd0, match, readback, product}, 0);
        RST = 1'b0;

        // Start on the first CLK after reset release.
        issue(4'd1, 4'd6, 7'h55, 0, 1);
        chk("busy_after_start", 32'(busy), 1);
        wait_done();
        issue(4'hF, 4'hF, 7'h00, 0, 1);
        wait_done();
        issue(4'd3, 4'd3, 7'h12, 1, 1);
        wait_done();

        // Start while busy is dropped; start in the FINISH cycle is dropped too.
        issue(4'd2, 4'd5, 7'h10, 0, 1);
        repeat (100) @(negedge CLK);
        issue(4'd7, 4'd7, 7'h20, 0, 0);
        chk("busy_after_ignored_start", 32'(busy), 1);
        wait_done();
        start = 1'b1; a = 4'd9; b = 4'd9; addr = 7'h40;
        @(negedge CLK);
        start = 1'b0;
        repeat (3) @(negedge CLK);
        chk("finish_start_ignored", 32'(busy), 0);

        // Reset in the middle of W_DATA.
        issue(4'd9, 4'd9, 7'h33, 0, 0);
        wait_rises(34);
        #3 RST = 1'b1;
        #1;
        chk("abort_memcs", 32'(MemCS), 1);
        chk("abort_sclk", 32'(SCLK), 0);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_multcs", 32'(MultCS), 0);
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        chk("abort_product", 32'(product), 0);

        for (int k = 0; k < 8; k++) begin
          issue(4'($urandom), 4'($urandom), 7'($urandom), $urandom_range(0, 3) == 0, 1);
          wait_done();
        end
        repeat (5) @(negedge CLK);
        chk("cs_overlap_cycles", 32'(cs_overlap), 0);
        chk("pending_expectations", 32'(exp_q.size()), 0);
        stim_done = 1;
      end
      // ---- monitor ----
      begin
        int   base;
        logic prev_done;
        exp_t e;
        base = 0; prev_done = 0;
        while (!stim_done) begin
          @(negedge CLK);
          if (RST) begin
            base = total_rises;
          end else if (done) begin
            chk("done_single_pulse", 32'(prev_done), 0);
            if (exp_q.size() == 0) begin
              chk("unexpected_done", 32'd1, 32'd0);
            end else begin
              e = exp_q.pop_front();
              chk("product", 32'(product), 32'(e.prod));
              chk("readback", 32'(readback), 32'(e.rb));
              chk("match", 32'(match), 32'(e.match));
              chk("mem_write_addr", 32'(mem_waddr), 32'(e.addr));
              chk("sclk_rises", 32'(total_rises - base), 32'(RISES));
              chk("busy_at_done", 32'(busy), 0);
            end
            base = total_rises;
          end
          prev_done = done;
        end
      end
    join
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
